// File: rtl/bit_sync_if.sv
// bit_sync_if: sample input and recovered-bit output bundle for bit_sync.
interface bit_sync_if;
  logic sample_valid;
  logic sample_bit;
  logic data_stream;
  logic write;
  logic locked;
  modport master(output sample_valid, sample_bit, input data_stream, write, locked);
  modport slave(input sample_valid, sample_bit, output data_stream, write, locked);
endinterface

// File: rtl/bit_sync.sv
// bit_sync: oversampled BPSK bit timing recovery with glitch filter, phase tracking and lock detect.
module bit_sync #(
  parameter int OVERSAMPLE = 16,
  parameter int LOCK_COUNT = 8
) (
  input logic       clk,
  input logic       rst_n,
  bit_sync_if.slave bus
);
  localparam int PW = $clog2(OVERSAMPLE);
  localparam int LW = $clog2(LOCK_COUNT + 1);
  localparam logic [PW-1:0] HALF = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] LAST = PW'(OVERSAMPLE - 1);
  localparam logic [PW-1:0] WRAP = PW'(OVERSAMPLE - 2);
  localparam logic [LW-1:0] LMAX = LW'(LOCK_COUNT);
  logic [2:0]    sr_q, sr_d, sh;
  logic          f_q, f_d, maj, trans, on_time;
  logic [PW-1:0] p_q, p_d, p_inc, p_fix;
  logic [LW-1:0] lc_q, lc_d;
  logic          data_q, data_d, write_q, write_d, locked_q, locked_d;
  always_comb begin
    sh       = {sr_q[1:0], bus.sample_bit};
    maj      = (sh[0] & sh[1]) | (sh[0] & sh[2]) | (sh[1] & sh[2]);
    trans    = bus.sample_valid && (maj != f_q);
    on_time  = (p_q == LAST) || (p_q <= PW'(1));
    p_inc    = (p_q == LAST) ? '0 : p_q + PW'(1);
    // late transitions stall one sample, early ones jump ahead by one extra
    p_fix    = (p_q == '0) ? PW'(1) : (p_q < HALF) ? p_q :
               (p_q >= WRAP) ? p_q - WRAP : p_q + PW'(2);
    sr_d     = bus.sample_valid ? sh : sr_q;
    f_d      = bus.sample_valid ? maj : f_q;
    p_d      = !bus.sample_valid ? p_q : trans ? p_fix : p_inc;
    lc_d     = !trans ? lc_q : !on_time ? '0 : (lc_q == LMAX) ? lc_q : lc_q + LW'(1);
    write_d  = bus.sample_valid && (p_q == HALF) && locked_q;
    data_d   = write_d ? maj : data_q;
    locked_d = (lc_q == LMAX);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      f_q      <= 1'b0;
      p_q      <= '0;
      lc_q     <= '0;
      data_q   <= 1'b0;
      write_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      f_q      <= f_d;
      p_q      <= p_d;
      lc_q     <= lc_d;
      data_q   <= data_d;
      write_q  <= write_d;
      locked_q <= locked_d;
    end
  end
  assign bus.data_stream = data_q;
  assign bus.write       = write_q;
  assign bus.locked      = locked_q;
endmodule

// File: tb/tb_bit_sync.sv
// tb_bit_sync: directed bench for bit_sync, one sample every two clocks at OVERSAMPLE=16.
module tb_bit_sync;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vecs = 0;
  int errs = 0;
  int nw = 0;
  int dbl = 0;
  logic wd = 1'b0;
  bit_sync_if bus();
  bit_sync dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp(input logic b);
    bus.sample_valid = 1'b1;
    bus.sample_bit = b;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    bus.sample_bit = ~b;
    if (bus.write === 1'b1) begin
      nw++;
      wd = bus.data_stream;
    end
  endtask

  task automatic idl();
    @(posedge clk); #1;
    if (bus.write !== 1'b0) dbl++;
  endtask

  task automatic send_bit(input logic b, input int n);
    nw = 0;
    repeat (n) begin
      smp(b);
      idl();
    end
  endtask

  task automatic acquire();
    nw = 0;
    repeat (15) begin
      smp(1'b0);
      idl();
    end
    for (int m = 1; m <= 7; m++) send_bit(logic'(m % 2), 16);
    chk("prelock_locked", {31'd0, bus.locked}, 32'd0);
    chk("prelock_writes", nw, 0);
    nw = 0;
    smp(1'b0); idl();
    smp(1'b0);
    chk("lock_lag", {31'd0, bus.locked}, 32'd0);
    idl();
    chk("lock_rise", {31'd0, bus.locked}, 32'd1);
    repeat (14) begin
      smp(1'b0);
      idl();
    end
    chk("bit8_write", {nw[30:0], wd}, {31'd1, 1'b0});
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_bit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.sample_valid = ~bus.sample_valid;
      bus.sample_bit = i[1];
      @(posedge clk); #1;
      chk("reset_outputs", {29'd0, bus.data_stream, bus.write, bus.locked}, 32'd0);
    end
    bus.sample_valid = 1'b0;
    rst_n = 1'b1;
    chk("reset_phase", {28'd0, dut.p_q}, 32'd0);
    acquire();
    for (int m = 9; m <= 16; m++) begin
      send_bit(logic'(m % 2), 16);
      chk("acq_bit", {nw[30:0], wd}, {31'd1, logic'(m % 2)});
    end
    for (int m = 17; m <= 80; m++) begin
      send_bit(logic'(m % 2), 17);
      chk("slow_bit", {nw[29:0], wd, bus.locked}, {30'd1, logic'(m % 2), 1'b1});
    end
    nw = 0;
    for (int i = 0; i < 16; i++) begin
      smp(i == 6 ? 1'b0 : 1'b1);
      idl();
    end
    chk("glitch_bit", {nw[29:0], wd, bus.locked}, {30'd1, 1'b1, 1'b1});
    chk("glitch_lc", {28'd0, dut.lc_q}, 32'd8);
    send_bit(1'b0, 16);
    chk("realign_bit", {nw[30:0], wd}, {31'd1, 1'b0});
    send_bit(1'b0, 8);
    smp(1'b1); idl();
    nw = 0;
    smp(1'b1);
    chk("early_phase", {28'd0, dut.p_q}, 32'd10);
    chk("early_lc", {28'd0, dut.lc_q}, 32'd0);
    chk("early_same_decision", {29'd0, bus.write, bus.data_stream, bus.locked}, 32'd7);
    idl();
    chk("early_unlock", {30'd0, bus.write, bus.locked}, 32'd0);
    send_bit(1'b1, 16);
    chk("early_no_write", {nw[30:0], bus.data_stream}, {31'd0, 1'b1});
    rst_n = 1'b0;
    idl();
    rst_n = 1'b1;
    acquire();
    send_bit(1'b1, 9);
    chk("pre_reset_writes", nw, 0);
    rst_n = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_bit = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    chk("midreset_outputs", {29'd0, bus.data_stream, bus.write, bus.locked}, 32'd0);
    chk("midreset_phase", {28'd0, dut.p_q}, 32'd0);
    @(posedge clk); #1;
    chk("midreset_hold", {29'd0, bus.data_stream, bus.write, bus.locked}, 32'd0);
    rst_n = 1'b1;
    acquire();
    send_bit(1'b1, 16);
    chk("relock_bit", {nw[30:0], wd}, {31'd1, 1'b1});
    chk("no_double_write", dbl, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
